instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the combinational instruction ROM for the pipeline IF stage.
//  - Owns the fetch PC and drives the ROM address.
//  - Captures {pc, instruction} pairs into a small prefetch FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Flushes and re-steers on branch, jump or exception redirect.
// PARAMETERS
//  DEPTH     4             prefetch FIFO entries; power of 2, >=2
//  RESET_PC  32'h0000_0000 fetch PC loaded on reset
//  ROM_BIT   7             ROM index width; ROM is word-indexed by addr[ROM_BIT+1:2]
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  rom_addr      out  32  byte address to ROM (= fetch_pc)
//  rom_data      in   32  ROM instruction word, valid same cycle as rom_addr
//  redirect      in   1   flush and restart fetch at redirect_pc
//  redirect_pc   in   32  new fetch address; bits [1:0] ignored (forced 0)
//  out_valid     out  1   FIFO head holds a valid instruction
//  out_ready     in   1   decode accepts head this cycle
//  out_instr     out  32  head instruction
//  out_pc        out  32  head PC
//  out_pc_plus4  out  32  out_pc + 4, mod 2^32
//  fifo_count    out  $clog2(DEPTH)+1  occupancy (debug/verification)
// BEHAVIOUR
//  Reset (async assert, sync deassert by caller):
//  - fetch_pc=RESET_PC; rd/wr pointers=0; count=0; out_valid=0.
//  - out_instr, out_pc and out_pc_plus4 read 0 while the FIFO is empty.
//  Outputs and pointers:
//  - rom_addr = fetch_pc, combinational.
//  - Outputs come from the registered FIFO head; there is no ROM-to-output bypass.
//  pop = out_valid & out_ready
//  push = ~redirect & (count<DEPTH | pop)
//  - On push: write {fetch_pc, rom_data}; wr_ptr++; fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
//  - On pop: rd_ptr++.
//  - count += push - pop. Pointers wrap modulo DEPTH.
//  - Full with simultaneous pop: push permitted, count unchanged.
//  - Full without pop: no push, fetch_pc holds.
//  - Empty: out_valid=0; out_ready is ignored.
//  Redirect (highest priority):
//  - Next edge: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[31:2],2'b00}.
//  - Same-cycle pop and push are discarded; the consumer must not commit the head in a redirect cycle.
//  - Back-to-back redirects: the last one wins; nothing is pushed in between.
//  Latency:
//  - First out_valid occurs 1 cycle after reset deassert or after a redirect edge.
//  - Sustained throughput is 1 instr/cycle while out_ready=1.
//  Handshake:
//  - While out_valid=1 & out_ready=0, out_instr, out_pc and out_pc_plus4 hold stable.
//  - out_valid never drops without a pop or a redirect.
//  Out-of-range ROM words (e.g. 32'h8000_0000) are passed through unmodified; no special handling.
// STRUCTURE
//  - Shared package holds: RESET_PC default, NOP word 32'h0000_0000, redirect-cause enum reserved for the exception unit.
//  - One sub-module: fetch_fifo (DEPTH x 64-bit synchronous FIFO).
//    - Signals: push/pop/clear; count, head outputs.
//    - clear has priority over push/pop.
//  - Top level keeps the fetch_pc register and the push/pop/redirect logic.
// TESTING
//  1. Reset, out_ready=1, ROM word0=32'h20080005, word1=32'h20090006
//     -> cycle1: out_pc=0, out_instr=20080005; cycle2: out_pc=4, out_instr=20090006.
//  2. out_ready=0 for 6 cycles after reset -> fifo_count reaches 4; fetch_pc holds 32'h10; head stays pc=0.
//     Then release -> pcs 0,4,8,C,10 delivered on consecutive cycles.
//  3. Redirect with redirect_pc=32'h1F while FIFO holds 3 entries
//     -> next cycle count=0, out_valid=0, rom_addr=32'h1C; following cycle out_pc=32'h1C, out_instr=32'h01096020.
//  4. Redirect asserted simultaneously with pop on a full FIFO -> pop discarded, count=0, no entry from that cycle appears.
//  5. Redirect to 32'hFFFF_FFF8, ready=1 -> out_pc sequence FFFFFFF8, FFFFFFFC, 0; out_pc_plus4 of FFFFFFFC is 0.
//  6. Assert reset mid-stream with count=3 -> out_valid=0 immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: reset PC default,
// NOP word, FIFO entry layout and the redirect cause reserved for the exception unit.
package instr_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   typedef enum logic [1:0] {
      REDIR_NONE      = 2'd0,
      REDIR_BRANCH    = 2'd1,
      REDIR_JUMP      = 2'd2,
      REDIR_EXCEPTION = 2'd3
   } redirect_cause_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// DEPTH x 64-bit synchronous prefetch FIFO; clear overrides push and pop.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [63:0]              wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     valid,
   output logic [63:0]              head
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q,  count_d;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic          push_ok, pop_ok;

   always_comb begin
      pop_ok  = pop & (count_q != '0);
      push_ok = push & ((count_q != FULL_CNT) | pop_ok);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign count = count_q;
   assign valid = (count_q != '0);
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// IF-stage sequencer: owns the fetch PC, fills the prefetch FIFO from the
// combinational ROM and hands {pc, instr} to decode over valid/ready.
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned ROM_BIT  = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              rom_addr,
   input  logic [31:0]              rom_data,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_pc_plus4,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_fetch_ctrl: DEPTH must be a power of 2 and >= 2");
   end
   if (ROM_BIT < 1 || ROM_BIT > 30) begin : g_bad_rom_bit
      $error("instr_fetch_ctrl: ROM_BIT out of range");
   end

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         push, pop;
   logic         fifo_valid;
   logic [63:0]  fifo_head;
   fetch_entry_t wr_entry, head_entry;
   logic         unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   always_comb begin
      pop  = fifo_valid & out_ready;
      push = ~redirect & ((fifo_count != FULL_CNT) | pop);

      wr_entry.pc    = fetch_pc_q;
      wr_entry.instr = rom_data;

      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Redirect drives clear, which discards any same-cycle push or pop inside the FIFO.
   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (redirect),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .count (fifo_count),
      .valid (fifo_valid),
      .head  (fifo_head)
   );

   always_comb begin
      head_entry   = fifo_head;
      rom_addr     = fetch_pc_q;
      out_valid    = fifo_valid;
      out_instr    = NOP_WORD;
      out_pc       = '0;
      out_pc_plus4 = '0;
      if (fifo_valid) begin
         out_instr    = head_entry.instr;
         out_pc       = head_entry.pc;
         out_pc_plus4 = head_entry.pc + 32'd4;
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a word-indexed ROM model.
module tb_instr_fetch_ctrl;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned ROM_BIT = 7;

   logic        clk;
   logic        reset;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [2:0]  fifo_count;

   logic [31:0] rom [2**ROM_BIT];
   int n_cmp;
   int n_mis;

   instr_fetch_ctrl #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000),
      .ROM_BIT  (ROM_BIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_pc_plus4 (out_pc_plus4),
      .fifo_count   (fifo_count)
   );

   assign rom_data = rom[rom_addr[ROM_BIT+1:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = rdy;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", out_valid); n_mis++; end n_cmp++;
      if (fifo_count !== 3'd0) begin $display("FAIL rst_count: got %0d want 0", fifo_count); n_mis++; end n_cmp++;
      if (rom_addr !== 32'h0) begin $display("FAIL rst_rom_addr: got %h want 00000000", rom_addr); n_mis++; end n_cmp++;
      if (out_instr !== 32'h0) begin $display("FAIL rst_instr: got %h want 00000000", out_instr); n_mis++; end n_cmp++;
      if (out_pc !== 32'h0) begin $display("FAIL rst_pc: got %h want 00000000", out_pc); n_mis++; end n_cmp++;
      if (out_pc_plus4 !== 32'h0) begin $display("FAIL rst_pc4: got %h want 00000000", out_pc_plus4); n_mis++; end n_cmp++;
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      tick();
      if (out_valid !== 1'b1) begin $display("FAIL s1_valid: got %b want 1", out_valid); n_mis++; end n_cmp++;
      if (out_pc !== 32'h0) begin $display("FAIL s1_pc: got %h want 00000000", out_pc); n_mis++; end n_cmp++;
      if (out_instr !== 32'h20080005) begin $display("FAIL s1_instr: got %h want 20080005", out_instr); n_mis++; end n_cmp++;
      if (out_pc_plus4 !== 32'h4) begin $display("FAIL s1_pc4: got %h want 00000004", out_pc_plus4); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'h4) begin $display("FAIL s2_pc: got %h want 00000004", out_pc); n_mis++; end n_cmp++;
      if (out_instr !== 32'h20090006) begin $display("FAIL s2_instr: got %h want 20090006", out_instr); n_mis++; end n_cmp++;
      if (fifo_count !== 3'd1) begin $display("FAIL s2_count: got %0d want 1", fifo_count); n_mis++; end n_cmp++;
      if (rom_addr !== 32'h8) begin $display("FAIL s2_rom_addr: got %h want 00000008", rom_addr); n_mis++; end n_cmp++;
   endtask

   task automatic test_stall_fill();
      logic [2:0]  exp_cnt;
      logic [31:0] exp_pc;
      do_reset(1'b0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_cnt = (k < 4) ? 3'(k) : 3'd4;
         if (fifo_count !== exp_cnt) begin $display("FAIL fill_count[%0d]: got %0d want %0d", k, fifo_count, exp_cnt); n_mis++; end n_cmp++;
         if (out_pc !== 32'h0 || out_valid !== 1'b1) begin $display("FAIL fill_head[%0d]: got pc=%h v=%b want pc=00000000 v=1", k, out_pc, out_valid); n_mis++; end n_cmp++;
      end
      if (rom_addr !== 32'h10) begin $display("FAIL fill_fetch_pc: got %h want 00000010", rom_addr); n_mis++; end n_cmp++;
      out_ready = 1'b1;
      #1;
      if (out_pc !== 32'h0) begin $display("FAIL drain_pc0: got %h want 00000000", out_pc); n_mis++; end n_cmp++;
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_pc = 32'(4 * k);
         if (out_pc !== exp_pc) begin $display("FAIL drain_pc[%0d]: got %h want %h", k, out_pc, exp_pc); n_mis++; end n_cmp++;
         if (fifo_count !== 3'd4) begin $display("FAIL drain_count[%0d]: got %0d want 4", k, fifo_count); n_mis++; end n_cmp++;
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b0);
      tick(); tick(); tick();
      if (fifo_count !== 3'd3) begin $display("FAIL rd_pre_count: got %0d want 3", fifo_count); n_mis++; end n_cmp++;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_001F;
      tick();
      redirect = 1'b0;
      if (fifo_count !== 3'd0) begin $display("FAIL rd_count: got %0d want 0", fifo_count); n_mis++; end n_cmp++;
      if (out_valid !== 1'b0) begin $display("FAIL rd_valid: got %b want 0", out_valid); n_mis++; end n_cmp++;
      if (rom_addr !== 32'h1C) begin $display("FAIL rd_rom_addr: got %h want 0000001c", rom_addr); n_mis++; end n_cmp++;
      if (out_instr !== 32'h0) begin $display("FAIL rd_instr_empty: got %h want 00000000", out_instr); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'h1C) begin $display("FAIL rd_pc: got %h want 0000001c", out_pc); n_mis++; end n_cmp++;
      if (out_instr !== 32'h01096020) begin $display("FAIL rd_instr: got %h want 01096020", out_instr); n_mis++; end n_cmp++;
      if (out_pc_plus4 !== 32'h20) begin $display("FAIL rd_pc4: got %h want 00000020", out_pc_plus4); n_mis++; end n_cmp++;
   endtask

   task automatic test_redirect_pop_full();
      do_reset(1'b0);
      for (int k = 0; k < 5; k++) tick();
      if (fifo_count !== 3'd4) begin $display("FAIL rp_pre_count: got %0d want 4", fifo_count); n_mis++; end n_cmp++;
      out_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      if (fifo_count !== 3'd0) begin $display("FAIL rp_count: got %0d want 0", fifo_count); n_mis++; end n_cmp++;
      if (out_valid !== 1'b0) begin $display("FAIL rp_valid: got %b want 0", out_valid); n_mis++; end n_cmp++;
      if (rom_addr !== 32'h40) begin $display("FAIL rp_rom_addr: got %h want 00000040", rom_addr); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'h40) begin $display("FAIL rp_pc: got %h want 00000040", out_pc); n_mis++; end n_cmp++;
      if (out_instr !== 32'hA500_0010) begin $display("FAIL rp_instr: got %h want a5000010", out_instr); n_mis++; end n_cmp++;
      if (fifo_count !== 3'd1) begin $display("FAIL rp_count2: got %0d want 1", fifo_count); n_mis++; end n_cmp++;
   endtask

   task automatic test_pc_wrap();
      out_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      if (rom_addr !== 32'hFFFF_FFF8) begin $display("FAIL wr_rom_addr: got %h want fffffff8", rom_addr); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'hFFFF_FFF8) begin $display("FAIL wr_pc0: got %h want fffffff8", out_pc); n_mis++; end n_cmp++;
      if (out_instr !== 32'hA500_007E) begin $display("FAIL wr_instr0: got %h want a500007e", out_instr); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'hFFFF_FFFC) begin $display("FAIL wr_pc1: got %h want fffffffc", out_pc); n_mis++; end n_cmp++;
      if (out_pc_plus4 !== 32'h0) begin $display("FAIL wr_pc4: got %h want 00000000", out_pc_plus4); n_mis++; end n_cmp++;
      if (out_instr !== 32'h8000_0000) begin $display("FAIL wr_instr1: got %h want 80000000", out_instr); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'h0) begin $display("FAIL wr_pc2: got %h want 00000000", out_pc); n_mis++; end n_cmp++;
      if (out_instr !== 32'h20080005) begin $display("FAIL wr_instr2: got %h want 20080005", out_instr); n_mis++; end n_cmp++;
   endtask

   task automatic test_back_to_back();
      out_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      if (fifo_count !== 3'd0 || rom_addr !== 32'h100) begin $display("FAIL bb_first: got cnt=%0d addr=%h want cnt=0 addr=00000100", fifo_count, rom_addr); n_mis++; end n_cmp++;
      redirect_pc = 32'h0000_0206;
      tick();
      redirect = 1'b0;
      if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin $display("FAIL bb_second: got cnt=%0d v=%b want cnt=0 v=0", fifo_count, out_valid); n_mis++; end n_cmp++;
      if (rom_addr !== 32'h204) begin $display("FAIL bb_rom_addr: got %h want 00000204", rom_addr); n_mis++; end n_cmp++;
      tick();
      if (out_pc !== 32'h204 || out_instr !== 32'h20090006) begin $display("FAIL bb_head: got pc=%h i=%h want pc=00000204 i=20090006", out_pc, out_instr); n_mis++; end n_cmp++;
   endtask

   task automatic test_async_reset();
      do_reset(1'b0);
      tick(); tick(); tick();
      if (fifo_count !== 3'd3) begin $display("FAIL ar_pre_count: got %0d want 3", fifo_count); n_mis++; end n_cmp++;
      #2;
      reset = 1'b0;
      #1;
      if (out_valid !== 1'b0) begin $display("FAIL ar_valid: got %b want 0", out_valid); n_mis++; end n_cmp++;
      if (fifo_count !== 3'd0) begin $display("FAIL ar_count: got %0d want 0", fifo_count); n_mis++; end n_cmp++;
      if (rom_addr !== 32'h0) begin $display("FAIL ar_rom_addr: got %h want 00000000", rom_addr); n_mis++; end n_cmp++;
      @(negedge clk);
      reset = 1'b1;
      tick();
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin $display("FAIL ar_restart: got v=%b pc=%h want v=1 pc=00000000", out_valid, out_pc); n_mis++; end n_cmp++;
      if (fifo_count !== 3'd1) begin $display("FAIL ar_count2: got %0d want 1", fifo_count); n_mis++; end n_cmp++;
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b0;
      for (int i = 0; i < 2**ROM_BIT; i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[0]   = 32'h20080005;
      rom[1]   = 32'h20090006;
      rom[7]   = 32'h01096020;
      rom[127] = 32'h8000_0000;

      test_reset();
      test_stream();
      test_stall_fill();
      test_redirect();
      test_redirect_pop_full();
      test_pc_wrap();
      test_back_to_back();
      test_async_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
